eth_tx: RTL and testbench

ETH_TX -- requirements
Module: eth_tx

---
 rtl/eth_tx.sv | 92 +++++++++
 tb/tb_eth_tx.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/eth_tx.sv
// eth_tx: builds one Avalon-ST result frame (header, meta, result bytes, zero pad)
// from a result buffer on each accepted send request.
module eth_tx #(
   parameter int          MMU_SIZE = 10,
   parameter logic [47:0] DEV_MAC  = 48'h5044332211EE
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        send,
   input  logic [47:0] host_mac,
   input  logic [7:0]  dim_x,
   input  logic [7:0]  dim_y,
   input  logic [7:0]  status,
   output logic [7:0]  res_addr,
   input  logic [7:0]  res_data,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   output logic        tx_sop,
   output logic        tx_eop,
   input  logic        tx_ready,
   output logic        tx_error,
   output logic        busy,
   output logic        done,
   output logic        req_error
);
   typedef enum logic [2:0] {IDLE, HEADER, META, DATA, PAD} state_t;
   localparam logic [7:0] DIM_MAX = 8'(MMU_SIZE);
   state_t      state, state_nx;
   logic [47:0] mac_q;
   logic [7:0]  dx_q, dy_q, st_q;
   logic [15:0] n_q, flen_q, ptr, n_in;
   logic [3:0]  hi;
   logic [1:0]  mi;
   logic        accept, xfer, last;
   assign n_in   = 16'(dim_x) * 16'(dim_y);
   assign accept = state == IDLE && send && dim_x != 8'd0 && dim_x <= DIM_MAX
                   && dim_y != 8'd0 && dim_y <= DIM_MAX;
   assign xfer   = tx_valid && tx_ready;
   assign last   = xfer && ptr == flen_q;
   assign hi     = 4'(ptr - 16'd1);
   assign mi     = 2'(ptr - 16'd15);
   always_ff @(posedge clk)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = accept ? HEADER : IDLE;
         HEADER:  if (xfer && ptr == 16'd14) state_nx = META;
         META:    if (xfer && ptr == 16'd18) state_nx = DATA;
         DATA:    if (xfer && ptr == n_q + 16'd18) state_nx = last ? IDLE : PAD;
         PAD:     if (last) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (!rst_n) begin
         ptr       <= 16'd1;
         mac_q     <= '0;
         dx_q      <= '0;
         dy_q      <= '0;
         st_q      <= '0;
         n_q       <= '0;
         flen_q    <= '0;
         done      <= 1'b0;
         req_error <= 1'b0;
      end else begin
         done      <= last;
         req_error <= state == IDLE && send && !accept;
         if (accept) begin
            mac_q  <= host_mac;
            dx_q   <= dim_x;
            dy_q   <= dim_y;
            st_q   <= status;
            n_q    <= n_in;
            flen_q <= n_in < 16'd42 ? 16'd60 : n_in + 16'd18;
         end
         if (xfer) ptr <= last ? 16'd1 : ptr + 16'd1;
      end
   // Outputs are decoded from state and pointer, so they hold naturally during stalls.
   always_comb begin
      tx_valid = state != IDLE;
      busy     = state != IDLE;
      tx_error = 1'b0;
      tx_sop   = state == HEADER && ptr == 16'd1;
      tx_eop   = tx_valid && ptr == flen_q;
      res_addr = state == DATA ? 8'(ptr - 16'd19) : 8'h00;
      tx_data  = state == HEADER ? 8'({mac_q, DEV_MAC, n_q + 16'd4} >> (7'd104 - {hi, 3'b000})) :
                 state == META   ? 8'({st_q, dx_q, dy_q, 8'h00} >> (5'd24 - {mi, 3'b000})) :
                 state == DATA   ? res_data : 8'h00;
   end
endmodule

// File: tb/tb_eth_tx.sv
// tb_eth_tx: directed frames checked every cycle against a byte-list model of the frame.
module tb_eth_tx;
   logic        clk = 1'b0, rst_n = 1'b0, send = 1'b0, tx_ready = 1'b1;
   logic [47:0] host_mac = '0;
   logic [7:0]  dim_x = '0, dim_y = '0, status = '0;
   logic [7:0]  res_addr, res_data, tx_data;
   logic        tx_valid, tx_sop, tx_eop, tx_error, busy, done, req_error;
   logic [7:0]  res_mem [0:255];
   logic [7:0]  exp_b [0:299];
   int          exp_len = 0, exp_n = 0, pos = 0, xfers = 0, frames = 0;
   int          passes = 0, total = 0;
   bit          active = 0, done_due = 0, rej_exp = 0, checking = 0, stall_mode = 0;

   always #5 clk = ~clk;
   assign res_data = res_mem[res_addr];

   eth_tx dut (
      .clk(clk), .rst_n(rst_n), .send(send), .host_mac(host_mac), .dim_x(dim_x),
      .dim_y(dim_y), .status(status), .res_addr(res_addr), .res_data(res_data),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_sop(tx_sop), .tx_eop(tx_eop),
      .tx_ready(tx_ready), .tx_error(tx_error), .busy(busy), .done(done), .req_error(req_error)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      total++;
      if (act === expv) passes++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
   endtask

   // Expected frame as a plain byte list: dst, src, length, meta, results, zero pad.
   task automatic build(input logic [47:0] mac, input logic [7:0] dx, input logic [7:0] dy,
                        input logic [7:0] st);
      logic [47:0] dev = 48'h5044332211EE;
      int n = int'(dx) * int'(dy);
      int k = 0;
      for (int i = 5; i >= 0; i--) begin exp_b[k] = mac[8*i +: 8]; k++; end
      for (int i = 5; i >= 0; i--) begin exp_b[k] = dev[8*i +: 8]; k++; end
      exp_b[k] = 8'((4 + n) >> 8); exp_b[k+1] = 8'(4 + n); k += 2;
      exp_b[k] = st; exp_b[k+1] = dx; exp_b[k+2] = dy; exp_b[k+3] = 8'h00; k += 4;
      for (int i = 0; i < n; i++) begin exp_b[k] = res_mem[i]; k++; end
      while (k < 60) begin exp_b[k] = 8'h00; k++; end
      exp_len = k;
      exp_n = n;
      pos = 0;
   endtask

   always @(negedge clk) if (rst_n && checking) begin
      chk("tx_valid", tx_valid, active);
      chk("busy", busy, active);
      chk("done", done, done_due);
      chk("req_error", req_error, rej_exp);
      chk("tx_error", tx_error, 0);
      done_due = 0;
      if (active && tx_valid) begin
         chk("tx_data", tx_data, exp_b[pos]);
         chk("tx_sop", tx_sop, pos == 0);
         chk("tx_eop", tx_eop, pos == exp_len - 1);
         chk("res_addr", res_addr, (pos >= 18 && pos < 18 + exp_n) ? pos - 18 : 0);
         if (tx_ready) begin
            xfers++;
            pos++;
            if (pos == exp_len) begin active = 0; done_due = 1; frames++; end
         end
      end
   end

   initial forever begin
      @(posedge clk);
      #1 tx_ready = stall_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
   end

   task automatic do_send(input logic [47:0] mac, input logic [7:0] dx, input logic [7:0] dy,
                          input logic [7:0] st, input bit ok);
      host_mac = mac; dim_x = dx; dim_y = dy; status = st; send = 1'b1;
      @(posedge clk);
      #1 send = 1'b0;
      host_mac = {$urandom, $urandom};
      dim_x = 8'($urandom); dim_y = 8'($urandom); status = 8'($urandom);
      if (ok) begin
         build(mac, dx, dy, st);
         active = 1;
      end else if (!active) begin
         rej_exp = 1;
         @(negedge clk);
         #1 rej_exp = 0;
      end
   endtask

   task automatic wait_idle();
      int c = 0;
      while (active && c < 1000) begin @(posedge clk); c++; end
      chk("frame_timeout", active, 0);
      active = 0;
      #1;
   endtask

   initial begin
      int f0, x0, c;
      for (int i = 0; i < 256; i++) res_mem[i] = 8'(i * 37 + 5);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", tx_valid, 0);
      chk("rst_data", tx_data, 0);
      chk("rst_addr", res_addr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_req_error", req_error, 0);
      chk("rst_sop_eop", {tx_sop, tx_eop}, 0);
      rst_n = 1'b1;
      checking = 1;
      repeat (2) @(posedge clk);
      #1;
      do_send(48'hDC0EA1F0573B, 8'd2, 8'd3, 8'h03, 1);
      chk("m23_len", exp_len, 60);
      chk("m23_lenfield", {exp_b[12], exp_b[13]}, 16'h000A);
      chk("m23_meta", {exp_b[14], exp_b[15], exp_b[16], exp_b[17]}, 32'h03020300);
      chk("m23_dst", exp_b[0], 8'hDC);
      chk("m23_src", exp_b[6], 8'h50);
      chk("m23_pad", {exp_b[24], exp_b[59]}, 16'h0000);
      wait_idle();
      repeat (3) @(posedge clk);
      #1;
      chk("frames_23", frames, 1);
      x0 = xfers;
      do_send(48'h0123456789AB, 8'd10, 8'd10, 8'h5A, 1);
      chk("m1010_len", exp_len, 118);
      chk("m1010_lenfield", {exp_b[12], exp_b[13]}, 16'h0068);
      wait_idle();
      chk("xfers_1010", xfers - x0, 118);
      repeat (2) @(posedge clk);
      #1;
      x0 = xfers;
      stall_mode = 1;
      do_send(48'h0123456789AB, 8'd10, 8'd10, 8'h5A, 1);
      wait_idle();
      stall_mode = 0;
      chk("xfers_stall", xfers - x0, 118);
      repeat (3) @(posedge clk);
      #1;
      do_send(48'h112233445566, 8'd0, 8'd5, 8'h01, 0);
      do_send(48'h112233445566, 8'd3, 8'd11, 8'h01, 0);
      repeat (3) @(posedge clk);
      #1;
      f0 = frames;
      do_send(48'hA1A2A3A4A5A6, 8'd4, 8'd4, 8'h44, 1);
      repeat (5) @(posedge clk);
      #1;
      do_send(48'hFFFFFFFFFFFF, 8'd2, 8'd2, 8'h99, 0);
      repeat (7) @(posedge clk);
      #1;
      do_send(48'hEEEEEEEEEEEE, 8'd1, 8'd1, 8'h98, 0);
      wait_idle();
      repeat (5) @(posedge clk);
      #1;
      chk("frames_ignored", frames - f0, 1);
      f0 = frames;
      do_send(48'hC0C1C2C3C4C5, 8'd3, 8'd3, 8'h33, 1);
      c = 0;
      while (pos != 29 && c < 1000) begin @(posedge clk); #1; c++; end
      chk("reach_byte30", pos, 29);
      rst_n = 1'b0;
      active = 0;
      done_due = 0;
      pos = 0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      chk("abort_valid", tx_valid, 0);
      repeat (4) @(posedge clk);
      #1;
      chk("abort_no_frame", frames - f0, 0);
      do_send(48'h0A0B0C0D0E0F, 8'd1, 8'd1, 8'h77, 1);
      chk("m11_len", exp_len, 60);
      chk("m11_lenfield", {exp_b[12], exp_b[13]}, 16'h0005);
      chk("m11_byte19", exp_b[18], 8'h05);
      wait_idle();
      repeat (3) @(posedge clk);
      #1;
      chk("frames_after_reset", frames - f0, 1);
      checking = 0;
      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule
